// File: rtl/updown_timer_ctrl.sv
// updown_timer_ctrl: parametrised up/down timer with wrap or stop-at-limit
// behaviour, preload, terminal-count pulse, sticky expiry and alarm compare.
// Every output is driven straight from a register. rst_n is expected to be
// released synchronously to clk_in by the upstream reset controller, so only
// its assertion is treated asynchronously here.

module updown_timer_ctrl #(
   parameter int WIDTH     = 14,
   parameter int MAX_COUNT = 5999
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             tick_en,
   input  logic [1:0]       key,
   input  logic             wrap_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] alarm_val,
   output logic [WIDTH-1:0] count,
   output logic             tc_pulse,
   output logic             expired,
   output logic             alarm_hit,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      ST_CLEARED = 3'd0,
      ST_UP      = 3'd1,
      ST_DOWN    = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   localparam logic [1:0]       KEY_UP    = 2'b00;
   localparam logic [1:0]       KEY_CLEAR = 2'b01;
   localparam logic [1:0]       KEY_HOLD  = 2'b10;
   localparam logic [1:0]       KEY_DOWN  = 2'b11;
   localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [WIDTH-1:0] count_r, count_s;
   logic             tc_r, tc_s;
   logic             expired_r, expired_s;
   logic             alarm_pend_r, alarm_pend_s;
   logic             alarm_r;

   // Preload values above the top count saturate at the top count.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX_C) ? MAX_C : v;
   endfunction

   // Next-state, next-count and flag decode in priority order:
   // load, clear, expired stall, normal counting.
   always_comb begin
      state_s   = state_r;
      count_s   = count_r;
      expired_s = expired_r;
      tc_s      = 1'b0;
      if (load) begin
         count_s   = clamp_load(load_val);
         expired_s = 1'b0;
         case (key)
            KEY_HOLD: state_s = ST_PAUSED;
            KEY_DOWN: state_s = ST_DOWN;
            default:  state_s = ST_UP;
         endcase
      end else if (key == KEY_CLEAR) begin
         count_s   = ZERO_C;
         expired_s = 1'b0;
         state_s   = ST_CLEARED;
      end else if (state_r == ST_EXPIRED) begin
         // Only a direction reversal away from the limit releases the stall.
         if ((key == KEY_DOWN) && (count_r == MAX_C)) begin
            state_s   = ST_DOWN;
            expired_s = 1'b0;
            if (tick_en) begin
               count_s = count_r - ONE_C;
            end else begin
               count_s = count_r;
            end
         end else if ((key == KEY_UP) && (count_r == ZERO_C)) begin
            state_s   = ST_UP;
            expired_s = 1'b0;
            if (tick_en) begin
               count_s = count_r + ONE_C;
            end else begin
               count_s = count_r;
            end
         end else begin
            state_s = ST_EXPIRED;
         end
      end else begin
         case (key)
            KEY_HOLD: state_s = ST_PAUSED;
            KEY_UP: begin
               state_s = ST_UP;
               if (!tick_en) begin
                  count_s = count_r;
               end else if (count_r < MAX_C) begin
                  count_s = count_r + ONE_C;
               end else if (wrap_en) begin
                  count_s = ZERO_C;
                  tc_s    = 1'b1;
               end else begin
                  tc_s      = 1'b1;
                  expired_s = 1'b1;
                  state_s   = ST_EXPIRED;
               end
            end
            KEY_DOWN: begin
               state_s = ST_DOWN;
               if (!tick_en) begin
                  count_s = count_r;
               end else if (count_r > ZERO_C) begin
                  count_s = count_r - ONE_C;
               end else if (wrap_en) begin
                  count_s = MAX_C;
                  tc_s    = 1'b1;
               end else begin
                  tc_s      = 1'b1;
                  expired_s = 1'b1;
                  state_s   = ST_EXPIRED;
               end
            end
            default: state_s = state_r;
         endcase
      end
   end

   // Flag a change of count onto the alarm value; the pulse itself is issued
   // one cycle later so it follows the new count on the outputs.
   always_comb begin
      if ((count_s != count_r) && (count_s == alarm_val)) begin
         alarm_pend_s = 1'b1;
      end else begin
         alarm_pend_s = 1'b0;
      end
   end

   // State, count and flag registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_CLEARED;
         count_r      <= ZERO_C;
         tc_r         <= 1'b0;
         expired_r    <= 1'b0;
         alarm_pend_r <= 1'b0;
         alarm_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         count_r      <= count_s;
         tc_r         <= tc_s;
         expired_r    <= expired_s;
         alarm_pend_r <= alarm_pend_s;
         alarm_r      <= alarm_pend_r;
      end
   end

   assign count     = count_r;
   assign tc_pulse  = tc_r;
   assign expired   = expired_r;
   assign alarm_hit = alarm_r;
   assign state     = state_r;

endmodule

// File: tb/tb_updown_timer_ctrl.sv
// Self-checking bench for updown_timer_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model of the timer.

module tb_updown_timer_ctrl;

   localparam int WIDTH = 14;
   localparam int MAX   = 5999;

   logic             clk_in;
   logic             rst_n;
   logic             tick_en;
   logic [1:0]       key;
   logic             wrap_en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] alarm_val;
   logic [WIDTH-1:0] count;
   logic             tc_pulse;
   logic             expired;
   logic             alarm_hit;
   logic [2:0]       state;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int m_count, m_exp, m_state, m_tc, m_alarm, m_pend;
   int tc_seen, alarm_seen;

   updown_timer_ctrl #(.WIDTH(WIDTH), .MAX_COUNT(MAX)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .tick_en   (tick_en),
      .key       (key),
      .wrap_en   (wrap_en),
      .load      (load),
      .load_val  (load_val),
      .alarm_val (alarm_val),
      .count     (count),
      .tc_pulse  (tc_pulse),
      .expired   (expired),
      .alarm_hit (alarm_hit),
      .state     (state)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count = 0; m_exp = 0; m_state = 0; m_tc = 0; m_alarm = 0; m_pend = 0;
   endtask

   // One clock of timer behaviour, straight from the rules in plain arithmetic.
   task automatic model_step();
      int prev, dir, nxt;
      prev    = m_count;
      m_tc    = 0;
      m_alarm = m_pend;
      if (load) begin
         m_count = (int'(load_val) > MAX) ? MAX : int'(load_val);
         m_exp   = 0;
         m_state = (key == 2'b10) ? 3 : ((key == 2'b11) ? 2 : 1);
      end else if (key == 2'b01) begin
         m_count = 0; m_exp = 0; m_state = 0;
      end else if (m_exp != 0) begin
         if ((key == 2'b11 && m_count == MAX) || (key == 2'b00 && m_count == 0)) begin
            m_exp   = 0;
            m_state = (key == 2'b11) ? 2 : 1;
            if (tick_en) m_count = m_count + ((key == 2'b11) ? -1 : 1);
         end
      end else if (key == 2'b10) begin
         m_state = 3;
      end else begin
         dir     = (key == 2'b00) ? 1 : -1;
         m_state = (key == 2'b00) ? 1 : 2;
         if (tick_en) begin
            nxt = m_count + dir;
            if (nxt > MAX || nxt < 0) begin
               m_tc = 1;
               if (wrap_en) m_count = (nxt < 0) ? MAX : 0;
               else begin
                  m_exp   = 1;
                  m_state = 4;
               end
            end else begin
               m_count = nxt;
            end
         end
      end
      m_pend = (m_count != prev && m_count == int'(alarm_val)) ? 1 : 0;
   endtask

   task automatic compare_all();
      check_eq("count", int'(count), m_count);
      check_eq("tc_pulse", int'(tc_pulse), m_tc);
      check_eq("expired", int'(expired), m_exp);
      check_eq("alarm_hit", int'(alarm_hit), m_alarm);
      check_eq("state", int'(state), m_state);
   endtask

   task automatic cycle();
      @(posedge clk_in);
      model_step();
      #1;
      compare_all();
      if (tc_pulse) tc_seen++;
      if (alarm_hit) alarm_seen++;
   endtask

   task automatic drive(input logic [1:0] k, input logic t, input logic w,
                        input logic l, input int lv);
      key      = k;
      tick_en  = t;
      wrap_en  = w;
      load     = l;
      load_val = WIDTH'(lv);
   endtask

   initial begin
      int exp_seq[5];
      int r;
      exp_seq = '{1, 0, 0, 0, 0};

      rst_n = 1'b0;
      drive(2'b10, 1'b0, 1'b1, 1'b0, 0);
      alarm_val = 14'h3FFF;
      model_reset();
      #1;
      compare_all();
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n = 1'b1;

      // Full up-count with wrap; alarm value out of range never fires.
      tc_seen = 0; alarm_seen = 0;
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 6000; i++) begin
         cycle();
         if (i == 5998) check_eq("up_reach_max", int'(count), 5999);
      end
      check_eq("up_wrap_count", int'(count), 0);
      check_eq("up_wrap_tc_total", tc_seen, 1);
      check_eq("up_wrap_expired", int'(expired), 0);
      check_eq("oor_alarm_silent", alarm_seen, 0);

      // Stop-at-zero going down, then reverse out of expiry.
      drive(2'b11, 1'b0, 1'b0, 1'b1, 2);
      cycle();
      tc_seen = 0;
      drive(2'b11, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_eq("down_stop_seq", int'(count), exp_seq[i]);
      end
      check_eq("down_stop_tc_total", tc_seen, 1);
      check_eq("down_stop_expired", int'(expired), 1);
      check_eq("down_stop_state", int'(state), 4);
      drive(2'b00, 1'b1, 1'b0, 1'b0, 0);
      cycle();
      check_eq("reverse_count", int'(count), 1);
      check_eq("reverse_expired", int'(expired), 0);
      check_eq("reverse_state", int'(state), 1);

      // Preload clamping and load-over-clear priority.
      drive(2'b11, 1'b0, 1'b0, 1'b1, 7000);
      cycle();
      check_eq("load_clamp_count", int'(count), 5999);
      check_eq("load_clamp_state", int'(state), 2);
      drive(2'b01, 1'b0, 1'b0, 1'b1, 7000);
      cycle();
      check_eq("load_beats_clear", int'(count), 5999);

      // Alarm compare at 10, then no repeat while holding.
      alarm_val = 14'd10;
      drive(2'b10, 1'b0, 1'b1, 1'b1, 8);
      cycle();
      alarm_seen = 0;
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0);
      cycle();
      cycle();
      check_eq("alarm_count10", int'(count), 10);
      check_eq("alarm_not_yet", int'(alarm_hit), 0);
      drive(2'b10, 1'b1, 1'b1, 1'b0, 0);
      cycle();
      check_eq("alarm_fires", int'(alarm_hit), 1);
      for (int i = 0; i < 20; i++) cycle();
      check_eq("alarm_once", alarm_seen, 1);

      // No movement without tick, then clear without tick.
      drive(2'b00, 1'b0, 1'b1, 1'b1, 1234);
      cycle();
      drive(2'b00, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 50; i++) cycle();
      check_eq("no_tick_hold", int'(count), 1234);
      drive(2'b01, 1'b0, 1'b1, 1'b0, 0);
      cycle();
      check_eq("clear_count", int'(count), 0);
      check_eq("clear_state", int'(state), 0);

      // Asynchronous reset in the middle of counting.
      drive(2'b00, 1'b1, 1'b1, 1'b1, 2990);
      cycle();
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 10; i++) cycle();
      check_eq("pre_reset_count", int'(count), 3000);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("async_rst_count", int'(count), 0);
      check_eq("async_rst_tc", int'(tc_pulse), 0);
      check_eq("async_rst_expired", int'(expired), 0);
      check_eq("async_rst_alarm", int'(alarm_hit), 0);
      check_eq("async_rst_state", int'(state), 0);
      @(posedge clk_in);
      #1;
      compare_all();
      @(negedge clk_in);
      rst_n = 1'b1;

      // Random phase: runs of keys, frequent loads near the limits.
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) key = 2'($urandom_range(0, 3));
         tick_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) wrap_en = 1'($urandom_range(0, 1));
         load = ($urandom_range(0, 15) == 0);
         r = int'($urandom_range(0, 3));
         case (r)
            0:       load_val = WIDTH'($urandom_range(0, 16383));
            1:       load_val = WIDTH'($urandom_range(0, 3));
            2:       load_val = WIDTH'($urandom_range(5995, 5999));
            default: load_val = WIDTH'($urandom_range(0, 5999));
         endcase
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0)
               alarm_val = WIDTH'((m_count + 1 > MAX) ? 0 : m_count + 1);
            else
               alarm_val = WIDTH'($urandom_range(0, 16383));
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
